// File: rtl/tx_frame_ctrl_if.sv
// Requester-side bundle for tx_frame_ctrl: payload offer, frame
// configuration, serial line and status.
interface tx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;
  logic                  ready;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, busy, ready
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, busy, ready
  );
endinterface

// File: rtl/tx_frame_ctrl.sv
// Serial frame transmitter: start bit, DATA_WIDTH payload bits LSB first,
// optional parity bit, stop bit. A one-entry holding register lets the
// next word be queued while a frame is on the line, so frames can be
// sent back to back with no idle cycle between them.
module tx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  tx_frame_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Active frame
  logic [2:0]            state_q,    state_nxt;
  logic [DATA_WIDTH-1:0] shift_q,    shift_nxt;
  logic [CNT_W-1:0]      cnt_q,      cnt_nxt;
  logic                  par_en_q,   par_en_nxt;
  logic                  par_bit_q,  par_bit_nxt;
  logic                  tx_q,       tx_nxt;

  // Holding register
  logic                  hold_full_q,    hold_full_nxt;
  logic [DATA_WIDTH-1:0] hold_data_q,    hold_data_nxt;
  logic                  hold_par_en_q,  hold_par_en_nxt;
  logic                  hold_par_bit_q, hold_par_bit_nxt;

  // Parity bit of the offered word, resolved at acceptance so later
  // PAR_TYP changes cannot alter a word already taken.
  logic                  in_par_bit;

  assign in_par_bit = (^bus.P_DATA) ^ bus.PAR_TYP;

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.ready  = ~hold_full_q;

  // Next-state, next-line-value and holding-register update
  always_comb begin
    state_nxt        = state_q;
    shift_nxt        = shift_q;
    cnt_nxt          = cnt_q;
    par_en_nxt       = par_en_q;
    par_bit_nxt      = par_bit_q;
    tx_nxt           = tx_q;
    hold_full_nxt    = hold_full_q;
    hold_data_nxt    = hold_data_q;
    hold_par_en_nxt  = hold_par_en_q;
    hold_par_bit_nxt = hold_par_bit_q;

    case (state_q)
      IDLE: begin
        tx_nxt = 1'b1;
        if (bus.DATA_VALID) begin
          shift_nxt   = bus.P_DATA;
          par_en_nxt  = bus.PAR_EN;
          par_bit_nxt = in_par_bit;
          cnt_nxt     = '0;
          state_nxt   = START;
          tx_nxt      = 1'b0;
        end
      end

      START: begin
        state_nxt = DATA;
        tx_nxt    = shift_q[0];
        shift_nxt = shift_q >> 1;
        cnt_nxt   = '0;
      end

      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit_q;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          tx_nxt    = shift_q[0];
          shift_nxt = shift_q >> 1;
          cnt_nxt   = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end

      STOP: begin
        // A queued word wins over a fresh offer; ready is low while it
        // is queued, so the fresh offer is not accepted on this edge.
        if (hold_full_q) begin
          shift_nxt     = hold_data_q;
          par_en_nxt    = hold_par_en_q;
          par_bit_nxt   = hold_par_bit_q;
          hold_full_nxt = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = START;
          tx_nxt        = 1'b0;
        end else if (bus.DATA_VALID) begin
          shift_nxt   = bus.P_DATA;
          par_en_nxt  = bus.PAR_EN;
          par_bit_nxt = in_par_bit;
          cnt_nxt     = '0;
          state_nxt   = START;
          tx_nxt      = 1'b0;
        end else begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase

    // Mid-frame acceptance goes into the holding register.
    if ((state_q == START || state_q == DATA || state_q == PARITY) &&
        bus.DATA_VALID && !hold_full_q) begin
      hold_full_nxt    = 1'b1;
      hold_data_nxt    = bus.P_DATA;
      hold_par_en_nxt  = bus.PAR_EN;
      hold_par_bit_nxt = in_par_bit;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      par_en_q       <= 1'b0;
      par_bit_q      <= 1'b0;
      tx_q           <= 1'b1;
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_bit_q <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      shift_q        <= shift_nxt;
      cnt_q          <= cnt_nxt;
      par_en_q       <= par_en_nxt;
      par_bit_q      <= par_bit_nxt;
      tx_q           <= tx_nxt;
      hold_full_q    <= hold_full_nxt;
      hold_data_q    <= hold_data_nxt;
      hold_par_en_q  <= hold_par_en_nxt;
      hold_par_bit_q <= hold_par_bit_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: stimulus pushes hand-computed line
// sequences; a negedge monitor pops one bit per busy cycle.
module tb_tx_frame_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  tx_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

  tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  bit   mon_en   = 1'b0;

  // Hand-computed frames, first line bit on the left
  localparam logic [15:0] F_A5_EVEN = 16'b01010010101;  // 11
  localparam logic [15:0] F_01_ODD  = 16'b01000000001;  // 11
  localparam logic [15:0] F_FF_NOP  = 16'b0111111111;   // 10
  localparam logic [15:0] F_3C_ODD  = 16'b00011110011;  // 11
  localparam logic [15:0] F_55_NOP  = 16'b0101010101;   // 10
  localparam logic [15:0] F_0F_NOP  = 16'b0111100001;   // 10

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_vec(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  // One-cycle offer; returns 1 time unit after the acceptance edge
  task automatic offer(input logic [7:0] d, input logic en, input logic typ);
    bus.P_DATA     = d;
    bus.PAR_EN     = en;
    bus.PAR_TYP    = typ;
    bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge CLK); #1;
      if (!bus.busy && exp_q.size() == 0) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  // Monitor: busy must track pending expected bits; each busy cycle
  // consumes one expected line bit, idle cycles must show a high line.
  always @(negedge CLK) begin
    if (mon_en) begin
      check("busy", bus.busy, (exp_q.size() > 0) ? 1'b1 : 1'b0);
      if (bus.busy && exp_q.size() > 0)
        check("tx_bit", bus.TX_OUT, exp_q.pop_front());
      else if (!bus.busy)
        check("tx_idle", bus.TX_OUT, 1'b1);
    end
  end

  initial begin
    bus.P_DATA     = 8'h3C;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    bus.DATA_VALID = 1'b1;   // offered under reset, must be discarded
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.DATA_VALID = 1'b0;
    check("rst_busy",  bus.busy,   1'b0);
    check("rst_ready", bus.ready,  1'b1);
    check("rst_tx",    bus.TX_OUT, 1'b1);
    mon_en = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end

    // Even parity 0xA5
    offer(8'hA5, 1'b1, 1'b0);
    push_vec(F_A5_EVEN, 11);
    wait_idle("done_a5_even");

    // Odd parity 0x01
    offer(8'h01, 1'b1, 1'b1);
    push_vec(F_01_ODD, 11);
    wait_idle("done_01_odd");

    // No parity 0xFF
    offer(8'hFF, 1'b0, 1'b0);
    push_vec(F_FF_NOP, 10);
    wait_idle("done_ff_nop");

    // Odd parity with an even count of ones
    offer(8'h3C, 1'b1, 1'b1);
    push_vec(F_3C_ODD, 11);
    wait_idle("done_3c_odd");

    // Back-to-back through the holding register
    offer(8'h55, 1'b0, 1'b0);          // now in frame cycle 1
    push_vec(F_55_NOP, 10);
    @(posedge CLK); #1;                 // cycle 2
    @(posedge CLK); #1;                 // cycle 3
    check("b2b_ready_before", bus.ready, 1'b1);
    bus.P_DATA     = 8'h0F;
    bus.PAR_EN     = 1'b0;
    bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;                 // cycle 4, 0x0F held
    push_vec(F_0F_NOP, 10);
    bus.P_DATA = 8'hC3;                 // third offer, must be ignored
    for (int i = 4; i <= 9; i++) begin
      check("b2b_ready_low", bus.ready, 1'b0);
      @(posedge CLK); #1;
    end
    bus.DATA_VALID = 1'b0;              // cycle 10, STOP of first frame
    check("b2b_ready_stop", bus.ready, 1'b0);
    @(posedge CLK); #1;                 // start bit of second frame
    check("b2b_ready_after", bus.ready, 1'b1);
    check("b2b_start_bit", bus.TX_OUT, 1'b0);
    wait_idle("done_b2b");

    // Reset mid-frame with the holding register full
    offer(8'hA5, 1'b1, 1'b0);          // cycle 1 (START)
    push_vec(F_A5_EVEN, 11);
    bus.P_DATA     = 8'h0F;
    bus.PAR_EN     = 1'b0;
    bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;                 // cycle 2, 0x0F held
    bus.DATA_VALID = 1'b0;
    push_vec(F_0F_NOP, 10);
    check("mid_hold_full", bus.ready, 1'b0);
    @(posedge CLK); #1;                 // cycle 3, DATA
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    check("mid_rst_tx",    bus.TX_OUT, 1'b1);
    check("mid_rst_busy",  bus.busy,   1'b0);
    check("mid_rst_ready", bus.ready,  1'b1);
    repeat (15) begin @(posedge CLK); #1; end

    // Recovery after reset needs a fresh offer
    offer(8'hFF, 1'b0, 1'b0);
    push_vec(F_FF_NOP, 10);
    wait_idle("done_recover");

    // Frame configuration latched at acceptance
    offer(8'hA5, 1'b1, 1'b0);
    push_vec(F_A5_EVEN, 11);
    for (int i = 0; i < 12; i++) begin
      bus.PAR_TYP = ~bus.PAR_TYP;
      @(posedge CLK); #1;
    end
    bus.PAR_TYP = 1'b0;
    wait_idle("done_cfg_latch");

    check("queue_drained", (exp_q.size() == 0) ? 1'b1 : 1'b0, 1'b1);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
